// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Pipelined immediate extender sitting between decode and execute. Decodes
// the 24-bit instruction immediate field into a WIDTH-bit operand plus a
// shifter carry-out, behind a valid/ready handshake with LATENCY register
// stages (1 or 2).
//
// Ports
//   CLK       rising-edge clock
//   RESETn    asynchronous active-low reset
//   Flush     synchronous kill of all in-flight beats
//   InValid   input beat valid
//   InReady   block accepts a beat this cycle (combinational on OutReady/Flush)
//   ImmSrc    extension mode: 000 rotate, 001 zext12, 010 branch,
//             011 split halfword, 100 sext12, 101..111 reserved
//   InstrImm  instruction bits [23:0]
//   CarryIn   current C flag (rotate mode)
//   OutValid  output beat valid (register output)
//   OutReady  downstream accepts the output beat
//   ExtImm    extended immediate (register output)
//   CarryOut  shifter carry-out (register output)
//   Illegal   output beat used a reserved ImmSrc (register output)
module imm_extend_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       ImmSrc,
    input  logic [23:0]      InstrImm,
    input  logic             CarryIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ExtImm,
    output logic             CarryOut,
    output logic             Illegal
);

    // Final-stage payload packs {Illegal, CarryOut, ExtImm}.
    localparam int RW = WIDTH + 2;
    localparam logic [6:0] WIDTH_U = 7'(WIDTH);

    function automatic logic [RW-1:0] extendImm(
        input logic [2:0]  src,
        input logic [23:0] imm,
        input logic        cin,
        input logic [4:0]  rot
    );
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] ext;
        logic [6:0]       lsh;
        logic             cout;
        logic             ill;
        v    = {{(WIDTH-8){1'b0}}, imm[7:0]};
        // Rotate right as (v >> r) | (v << (WIDTH-r)); for r == 0 the left
        // shift is by the full width and contributes nothing.
        lsh  = WIDTH_U - {2'b00, rot};
        ext  = '0;
        cout = cin;
        ill  = 1'b0;
        case (src)
            3'b000: begin
                ext  = (v >> rot) | (v << lsh);
                cout = (rot == 5'd0) ? cin : ext[WIDTH-1];
            end
            3'b001: ext = {{(WIDTH-12){1'b0}}, imm[11:0]};
            3'b010: ext = {{(WIDTH-26){imm[23]}}, imm, 2'b00};
            3'b011: ext = {{(WIDTH-8){1'b0}}, imm[11:8], imm[3:0]};
            3'b100: ext = {{(WIDTH-12){imm[11]}}, imm[11:0]};
            default: ill = 1'b1;
        endcase
        return {ill, cout, ext};
    endfunction

    logic [4:0]    inRot;
    logic          outV;
    logic [RW-1:0] outReg;
    logic          lastReady;

    assign inRot     = {InstrImm[11:8], 1'b0};
    assign lastReady = !outV || OutReady;
    assign OutValid  = outV;
    assign {Illegal, CarryOut, ExtImm} = outReg;

    generate
        if (LATENCY == 1) begin : g_lat1
            assign InReady = lastReady && !Flush;

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    outV   <= 1'b0;
                    outReg <= '0;
                end else if (Flush) begin
                    outV <= 1'b0;
                end else if (lastReady) begin
                    outV <= InValid;
                    if (InValid) begin
                        outReg <= extendImm(ImmSrc, InstrImm, CarryIn, inRot);
                    end
                end
            end
        end else begin : g_lat2
            logic        s0V;
            logic        s0Ready;
            logic [2:0]  s0Src;
            logic [23:0] s0Imm;
            logic        s0Cin;
            logic [4:0]  s0Rot;

            assign s0Ready = !s0V || lastReady;
            assign InReady = s0Ready && !Flush;

            // Stage 0 captures the raw fields and the rotate amount only.
            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    s0V   <= 1'b0;
                    s0Src <= '0;
                    s0Imm <= '0;
                    s0Cin <= 1'b0;
                    s0Rot <= '0;
                end else if (Flush) begin
                    s0V <= 1'b0;
                end else if (s0Ready) begin
                    s0V <= InValid;
                    if (InValid) begin
                        s0Src <= ImmSrc;
                        s0Imm <= InstrImm;
                        s0Cin <= CarryIn;
                        s0Rot <= inRot;
                    end
                end
            end

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    outV   <= 1'b0;
                    outReg <= '0;
                end else if (Flush) begin
                    outV <= 1'b0;
                end else if (lastReady) begin
                    outV <= s0V;
                    if (s0V) begin
                        outReg <= extendImm(s0Src, s0Imm, s0Cin, s0Rot);
                    end
                end
            end
        end
    endgenerate

endmodule
